// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32 multi-cycle control path: FSM states, opcodes,
// ALU operation classes/codes, datapath mux selects and the control word.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_EXEC     = 4'd7,
        ST_ALU_WB   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_TRAP     = 4'd10
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;

    // funct = {IR[30], IR[14:12]}
    localparam logic [3:0] FUNCT_ADD = 4'b0000;
    localparam logic [3:0] FUNCT_SUB = 4'b1000;
    localparam logic [3:0] FUNCT_AND = 4'b0111;
    localparam logic [3:0] FUNCT_OR  = 4'b0110;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_REG    = 2'b01;
    localparam logic [1:0] SRCA_OLD_PC = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic PCSRC_ALU    = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;
    localparam logic IORD_PC      = 1'b0;
    localparam logic IORD_ALUOUT  = 1'b1;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal_instr;
    } ctrl_t;

    function automatic ctrl_t ctrl_none();
        ctrl_t c;
        c = '0;
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_dec.sv
// Combinational ALU-operation decoder: alu_op class plus funct bits to the
// 4-bit ALU operation. Shared with the single-cycle datapath.
module alu_op_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [3:0] funct,
    output logic [3:0] alu_operation
);

    always_comb begin
        alu_operation = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_operation = ALU_ADD;
            ALUOP_SUB: alu_operation = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_operation = ALU_ADD;
                    FUNCT_SUB: alu_operation = ALU_SUB;
                    FUNCT_AND: alu_operation = ALU_AND;
                    FUNCT_OR:  alu_operation = ALU_OR;
                    default:   alu_operation = ALU_ADD;
                endcase
            end
            default: alu_operation = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencing controller for the RV32 datapath (fetch, decode,
// execute, memory, writeback) with ready-handshaked memory accesses.
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [3:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [3:0] alu_operation,
    output logic       instr_done,
    output logic       illegal_instr
);

    state_t state_reg, state_next;
    // Load/store distinction must survive past DECODE, the only cycle opcode is valid.
    logic   is_store_reg, is_store_next;
    ctrl_t  ctrl;
    logic [3:0] dec_operation;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            is_store_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            is_store_reg <= is_store_next;
        end
    end

    always_comb begin
        ctrl          = ctrl_none();
        state_next    = state_reg;
        is_store_next = is_store_reg;
        case (state_reg)
            ST_IDLE: state_next = ST_FETCH;
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = IORD_PC;
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                if (mem_ready) begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ctrl.alu_src_a = SRCA_OLD_PC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                case (opcode)
                    OPC_LOAD: begin
                        state_next    = ST_MEM_ADDR;
                        is_store_next = 1'b0;
                    end
                    OPC_STORE: begin
                        state_next    = ST_MEM_ADDR;
                        is_store_next = 1'b1;
                    end
                    OPC_OP:     state_next = ST_EXEC;
                    OPC_BRANCH: state_next = ST_BRANCH;
                    default:    state_next = ST_TRAP;
                endcase
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = SRCA_REG;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                state_next     = is_store_reg ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = IORD_ALUOUT;
                if (mem_ready) begin
                    state_next = ST_MEM_WB;
                end
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
                state_next      = ST_FETCH;
            end
            ST_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = IORD_ALUOUT;
                ctrl.instr_done = mem_ready;
                if (mem_ready) begin
                    state_next = ST_FETCH;
                end
            end
            ST_EXEC: begin
                ctrl.alu_src_a = SRCA_REG;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
                state_next     = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.instr_done = 1'b1;
                state_next      = ST_FETCH;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = SRCA_REG;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
                state_next         = ST_FETCH;
            end
            ST_TRAP: begin
                ctrl.illegal_instr = 1'b1;
                state_next         = ST_FETCH;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    alu_op_decode u_alu_op_decode (
        .alu_op        (ctrl.alu_op),
        .funct         (funct),
        .alu_operation (dec_operation)
    );

    // IDLE drives a fully quiet control word, including the ALU operation.
    assign alu_operation = (state_reg == ST_IDLE) ? 4'b0000 : dec_operation;

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_source     = ctrl.pc_source;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign instr_done    = ctrl.instr_done;
    assign illegal_instr = ctrl.illegal_instr;

endmodule
